// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer.
// Entry layout, pointer width and word-index helper.
package store_buffer_pkg;

  localparam int SB_DEPTH      = 4;
  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;
  localparam int SB_PTR_W      = $clog2(SB_DEPTH) + 1;
  localparam int SB_IDX_W      = SB_PTR_W - 1;

  typedef struct packed {
    logic                     valid;
    logic [SB_ADDR_WIDTH-3:0] word;
    logic [SB_DATA_WIDTH-1:0] data;
  } sb_entry_t;

  function automatic logic [SB_ADDR_WIDTH-3:0] word_of(
    input logic [SB_ADDR_WIDTH-1:0] addr
  );
    return addr[SB_ADDR_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/sb_forward_match.sv
// Youngest-match selector: walks entries oldest to youngest
// starting at head, so the last hit seen is nearest the tail.
module sb_forward_match #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0] match,
  input  logic [IDX_W-1:0] head,
  output logic             hit,
  output logic [IDX_W-1:0] sel
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    hit = 1'b0;
    sel = head;
    idx = head;
    for (int age = 0; age < DEPTH; age++) begin
      idx = head + IDX_W'(age);
      if (match[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer with load forwarding and REQ/ACK drain.
// Optional in-place merging of stores: STORE_BUFFER_COALESCE_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = SB_DEPTH,
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SIG_WRITE,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_DATA,
  output logic [DATA_WIDTH-1:0] MEM_READ,
  output logic                  STALL,
  output logic                  OVERFLOW,
  output logic                  EMPTY,
  output logic                  BK_REQ,
  output logic [ADDR_WIDTH-1:0] BK_WADDR,
  output logic [DATA_WIDTH-1:0] BK_WDATA,
  input  logic                  BK_ACK,
  output logic [ADDR_WIDTH-1:0] BK_RADDR,
  input  logic [DATA_WIDTH-1:0] BK_RDATA
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  sb_entry_t        ent [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [IDX_W-1:0] head_i, tail_i;
  logic             ovf;
  logic             empty, full;
  logic             pop, push, coal;
  logic [ADDR_WIDTH-3:0] in_word;
  logic [DEPTH-1:0] match;
  logic             hit;
  logic [IDX_W-1:0] sel;

  assign head_i  = head[IDX_W-1:0];
  assign tail_i  = tail[IDX_W-1:0];
  assign in_word = word_of(MEM_ADDR);

  assign empty = (head == tail);
  assign full  = (head_i == tail_i) &&
                 (head[PTR_W-1] != tail[PTR_W-1]);

  assign pop = BK_REQ && BK_ACK;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [IDX_W-1:0] last_i;
  assign last_i = tail_i - 1'b1;
  // Head is excluded so the word on the memory bus never changes.
  assign coal = SIG_WRITE && ent[last_i].valid &&
                (ent[last_i].word == in_word) &&
                (last_i != head_i);
`else
  assign coal = 1'b0;
`endif

  assign STALL = SIG_WRITE && full && !pop && !coal;
  assign push  = SIG_WRITE && !STALL && !coal;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head <= '0;
      tail <= '0;
      ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        ent[i] <= '0;
    end else begin
      if (STALL)
        ovf <= 1'b1;
`ifdef STORE_BUFFER_COALESCE_EN
      if (coal)
        ent[last_i].data <= MEM_DATA;
`endif
      if (pop) begin
        ent[head_i].valid <= 1'b0;
        head <= head + 1'b1;
      end
      // On a full pop+push, tail_i equals head_i; push wins.
      if (push) begin
        ent[tail_i].valid <= 1'b1;
        ent[tail_i].word  <= in_word;
        ent[tail_i].data  <= MEM_DATA;
        tail <= tail + 1'b1;
      end
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = ent[i].valid && (ent[i].word == in_word);
  end

  sb_forward_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_fwd (
    .match (match),
    .head  (head_i),
    .hit   (hit),
    .sel   (sel)
  );

  assign MEM_READ = hit ? ent[sel].data : BK_RDATA;
  assign BK_RADDR = MEM_ADDR & ~ADDR_WIDTH'(3);
  assign EMPTY    = empty;
  assign BK_REQ   = !empty;
  assign OVERFLOW = ovf;
  assign BK_WADDR = ent[head_i].valid ? {ent[head_i].word, 2'b00} : '0;
  assign BK_WDATA = ent[head_i].valid ? ent[head_i].data : '0;

endmodule
